// File: rtl/audio_sched_if.sv
// Bus between the audio scheduler and its controller: request inputs plus
// grant/beat status outputs. The scheduler side uses the slave modport.
interface audio_sched_if;
    logic       bgm_en;
    logic [1:0] sfx_req;
    logic [2:0] grant;
    logic [7:0] beat_idx;
    logic       beat_tick;
    logic       mute;

    modport master (
        output bgm_en,
        output sfx_req,
        input  grant,
        input  beat_idx,
        input  beat_tick,
        input  mute
    );

    modport slave (
        input  bgm_en,
        input  sfx_req,
        output grant,
        output beat_idx,
        output beat_tick,
        output mute
    );
endinterface

// File: rtl/audio_sched.sv
// Audio scheduler: arbitrates BGM and two sound effects onto one tone generator
// and keeps beat timing. Define SFX_QUEUE_EN to hold one pending SFX0 during SFX1.
module audio_sched #(
    parameter int CLK_HZ     = 100000000,
    parameter int BEAT_HZ    = 8,
    parameter int BGM_BEATS  = 128,
    parameter int SFX0_BEATS = 4,
    parameter int SFX1_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst,
    audio_sched_if.slave bus
);

    localparam int DIV   = CLK_HZ / BEAT_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [7:0]       BGM_LAST  = 8'(BGM_BEATS - 1);
    localparam logic [7:0]       SFX0_LAST = 8'(SFX0_BEATS - 1);
    localparam logic [7:0]       SFX1_LAST = 8'(SFX1_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BGM  = 2'd1,
        SFX0 = 2'd2,
        SFX1 = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       beat_idx_q, beat_idx_d;
    logic [7:0]       saved_q, saved_d;

    logic       tick;
    logic       sfx_done;
    logic       restart;
    logic       sfx0_waiting;
    logic [7:0] bgm_adv;

    // A beat ends on the last divider count; nothing counts while idle.
    assign tick    = (state_q != IDLE) && (div_q == DIV_LAST);
    assign bgm_adv = (beat_idx_q == BGM_LAST) ? 8'd0 : beat_idx_q + 8'd1;

    always_comb begin
        sfx_done = 1'b0;
        case (state_q)
            SFX0:    sfx_done = tick && (beat_idx_q == SFX0_LAST);
            SFX1:    sfx_done = tick && (beat_idx_q == SFX1_LAST);
            default: sfx_done = 1'b0;
        endcase
    end

`ifdef SFX_QUEUE_EN
    logic pend_q, pend_d;

    // A request arriving on the very edge SFX1 finishes still counts as pending.
    assign sfx0_waiting = pend_q | bus.sfx_req[0];

    always_comb begin
        pend_d = pend_q;
        if (bus.sfx_req[0] && (state_d == SFX1)) begin
            pend_d = 1'b1;
        end
        if ((state_q == SFX1) && (state_d == SFX0)) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    assign sfx0_waiting = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        beat_idx_d = beat_idx_q;
        saved_d    = saved_q;
        restart    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sfx_req[1]) begin
                    state_d = SFX1;
                end else if (bus.sfx_req[0]) begin
                    state_d = SFX0;
                end else if (bus.bgm_en) begin
                    state_d = BGM;
                end
            end
            BGM: begin
                if (bus.sfx_req[1]) begin
                    state_d = SFX1;
                end else if (bus.sfx_req[0]) begin
                    state_d = SFX0;
                end else if (!bus.bgm_en) begin
                    state_d = IDLE;
                end
            end
            SFX0: begin
                if (bus.sfx_req[1]) begin
                    state_d = SFX1;
                end else if (bus.sfx_req[0]) begin
                    restart = 1'b1;
                end else if (sfx_done) begin
                    state_d = bus.bgm_en ? BGM : IDLE;
                end
            end
            SFX1: begin
                if (bus.sfx_req[1]) begin
                    restart = 1'b1;
                end else if (sfx_done) begin
                    if (sfx0_waiting) begin
                        state_d = SFX0;
                    end else begin
                        state_d = bus.bgm_en ? BGM : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A beat that completes on the preempting edge counts as played.
        if ((state_q == BGM) && ((state_d == SFX0) || (state_d == SFX1))) begin
            saved_d = tick ? bgm_adv : beat_idx_q;
        end
        if (!bus.bgm_en) begin
            saved_d = 8'd0;
        end

        if ((state_d != state_q) || restart) begin
            div_d      = '0;
            beat_idx_d = (state_d == BGM) ? saved_q : 8'd0;
        end else if (tick) begin
            div_d      = '0;
            beat_idx_d = (state_q == BGM) ? bgm_adv : beat_idx_q + 8'd1;
        end else if (state_q != IDLE) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            beat_idx_q <= 8'd0;
            saved_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            beat_idx_q <= beat_idx_d;
            saved_q    <= saved_d;
        end
    end

    // grant bit gi is owned by state code gi+1
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_grant
            assign bus.grant[gi] = (state_q == state_t'(2'(gi + 1)));
        end
    endgenerate

    assign bus.beat_idx  = beat_idx_q;
    assign bus.beat_tick = tick;
    assign bus.mute      = (state_q == IDLE);

endmodule

// File: tb/tb_audio_sched.sv
// Directed and random checks of audio_sched against a rule-level owner/beat model
// (one beat = 10 cycles).
module tb_audio_sched;

    localparam int CLK_HZ     = 80;
    localparam int BEAT_HZ    = 8;
    localparam int BGM_BEATS  = 128;
    localparam int SFX0_BEATS = 4;
    localparam int SFX1_BEATS = 16;
    localparam int BEAT_CYC   = CLK_HZ / BEAT_HZ;
`ifdef SFX_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic clk;
    logic rst;
    audio_sched_if bus ();

    audio_sched #(
        .CLK_HZ    (CLK_HZ),
        .BEAT_HZ   (BEAT_HZ),
        .BGM_BEATS (BGM_BEATS),
        .SFX0_BEATS(SFX0_BEATS),
        .SFX1_BEATS(SFX1_BEATS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: owner 0=none 1=BGM 2=SFX0 3=SFX1, beat position, cycles into beat.
    int m_owner, m_pos, m_cnt, m_saved;
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit b, input logic [1:0] s);
        bit tick, done, restart, wants_sfx0;
        int nxt, new_saved, len;
        if (r) begin
            m_owner = 0; m_pos = 0; m_cnt = 0; m_saved = 0; m_pend = 0;
            return;
        end
        tick       = (m_owner != 0) && (m_cnt == BEAT_CYC - 1);
        len        = (m_owner == 2) ? SFX0_BEATS : SFX1_BEATS;
        done       = (m_owner >= 2) && tick && (m_pos == len - 1);
        wants_sfx0 = QUEUE && (m_pend || s[0]);
        restart    = 0;
        nxt        = m_owner;
        if (s[1]) begin
            nxt = 3; restart = (m_owner == 3);
        end else if (s[0] && m_owner != 3) begin
            nxt = 2; restart = (m_owner == 2);
        end else if (m_owner == 0 && b) begin
            nxt = 1;
        end else if (m_owner == 1 && !b) begin
            nxt = 0;
        end else if (done) begin
            nxt = (m_owner == 3 && wants_sfx0) ? 2 : (b ? 1 : 0);
        end
        new_saved = m_saved;
        if (m_owner == 1 && nxt >= 2) new_saved = tick ? (m_pos + 1) % BGM_BEATS : m_pos;
        if (!b) new_saved = 0;
        if (QUEUE && s[0] && nxt == 3) m_pend = 1;
        if (m_owner == 3 && nxt == 2) m_pend = 0;
        if (nxt != m_owner || restart) begin
            m_cnt = 0;
            m_pos = (nxt == 1) ? m_saved : 0;
        end else if (tick) begin
            m_cnt = 0;
            m_pos = (m_owner == 1) ? (m_pos + 1) % BGM_BEATS : m_pos + 1;
        end else if (m_owner != 0) begin
            m_cnt++;
        end
        m_saved = new_saved;
        m_owner = nxt;
    endtask

    task automatic cycle(input bit r, input bit b, input logic [1:0] s);
        logic [2:0] exp_grant;
        rst         = r;
        bus.bgm_en  = b;
        bus.sfx_req = s;
        @(posedge clk);
        model_step(r, b, s);
        cyc++;
        @(negedge clk);
        exp_grant = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
        chk("grant",     32'(bus.grant),     32'(exp_grant));
        chk("beat_idx",  32'(bus.beat_idx),  32'(m_pos));
        chk("beat_tick", 32'(bus.beat_tick), 32'((m_owner != 0) && (m_cnt == BEAT_CYC - 1)));
        chk("mute",      32'(bus.mute),      32'(m_owner == 0));
    endtask

    task automatic run(input int n, input bit b);
        for (int i = 0; i < n; i++) cycle(1'b0, b, 2'b00);
    endtask

    initial begin
        logic [1:0] s;
        bit         b;
        int         p;
        m_owner = 0; m_pos = 0; m_cnt = 0; m_saved = 0; m_pend = 0;
        rst = 1'b1; bus.bgm_en = 1'b0; bus.sfx_req = 2'b00;

        // Reset state, with requests asserted to show reset wins
        cycle(1'b1, 1'b1, 2'b11);
        cycle(1'b1, 1'b0, 2'b00);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_mute",  32'(bus.mute),  32'd1);
        chk("rst_idx",   32'(bus.beat_idx), 32'd0);

        // BGM start and wrap
        cycle(1'b0, 1'b1, 2'b00);
        chk("bgm_grant", 32'(bus.grant), 32'b001);
        chk("bgm_mute",  32'(bus.mute),  32'd0);
        run(1270, 1'b1);
        chk("bgm_idx127", 32'(bus.beat_idx), 32'd127);
        run(10, 1'b1);
        chk("bgm_wrap", 32'(bus.beat_idx), 32'd0);

        // SFX0 preempts BGM at beat 5, BGM resumes at beat 5
        run(53, 1'b1);
        chk("bgm_idx5", 32'(bus.beat_idx), 32'd5);
        cycle(1'b0, 1'b1, 2'b01);
        chk("sfx0_grant", 32'(bus.grant), 32'b010);
        chk("sfx0_idx0",  32'(bus.beat_idx), 32'd0);
        run(39, 1'b1);
        chk("sfx0_last", 32'(bus.grant), 32'b010);
        run(1, 1'b1);
        chk("resume_grant", 32'(bus.grant), 32'b001);
        chk("resume_idx",   32'(bus.beat_idx), 32'd5);

        // SFX1 preempts SFX0; SFX0 is not resumed
        cycle(1'b0, 1'b1, 2'b01);
        run(5, 1'b1);
        cycle(1'b0, 1'b1, 2'b10);
        chk("preempt_grant", 32'(bus.grant), 32'b100);
        run(159, 1'b1);
        chk("sfx1_last", 32'(bus.grant), 32'b100);
        run(1, 1'b1);
        chk("after_sfx1", 32'(bus.grant), 32'b001);

        // Simultaneous requests from IDLE
        cycle(1'b0, 1'b0, 2'b00);
        chk("bgm_off", 32'(bus.grant), 32'b000);
        cycle(1'b0, 1'b0, 2'b11);
        chk("both_grant", 32'(bus.grant), 32'b100);
        run(159, 1'b0);
        run(1, 1'b0);
        chk("after_both", 32'(bus.grant), QUEUE ? 32'b010 : 32'b000);
        if (QUEUE) begin
            run(39, 1'b0);
            chk("queued_sfx0", 32'(bus.grant), 32'b010);
            run(1, 1'b0);
            chk("queued_end", 32'(bus.grant), 32'b000);
        end

        // Reset mid-beat in SFX1 beat 7
        cycle(1'b0, 1'b0, 2'b10);
        run(74, 1'b0);
        chk("sfx1_idx7", 32'(bus.beat_idx), 32'd7);
        cycle(1'b1, 1'b0, 2'b00);
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_tick",  32'(bus.beat_tick), 32'd0);
        chk("mid_rst_mute",  32'(bus.mute), 32'd1);

        // bgm_en drop clears BGM position
        cycle(1'b0, 1'b1, 2'b00);
        run(35, 1'b1);
        chk("bgm_idx3", 32'(bus.beat_idx), 32'd3);
        cycle(1'b0, 1'b0, 2'b00);
        chk("drop_grant", 32'(bus.grant), 32'b000);
        cycle(1'b0, 1'b1, 2'b00);
        chk("restart_grant", 32'(bus.grant), 32'b001);
        chk("restart_idx",   32'(bus.beat_idx), 32'd0);

        // Random traffic against the model
        b = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) b = ~b;
            p = int'($urandom_range(0, 199));
            s = (p == 0) ? 2'b01 : (p == 1) ? 2'b10 : (p == 2) ? 2'b11 : 2'b00;
            cycle($urandom_range(0, 799) == 0, b, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_sched.md
AUDIO_SCHED -- requirements
Module: audio_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Parameter CLK_HZ, 100000000, system clock frequency.
REQ-003 Parameter BEAT_HZ, 8, beats per second; one beat lasts 1/8 s by default.
REQ-004 Parameter BGM_BEATS, 128, background-music loop length in beats.
REQ-005 Parameter SFX0_BEATS, 4, length of effect 0 ("hit") in beats.
REQ-006 Parameter SFX1_BEATS, 16, length of effect 1 ("win") in beats.
REQ-007 clk  in  1  system clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 bgm_en  in  1  level; background music is requested while high.
REQ-010 sfx_req  in  2  one-cycle request pulses; bit0 requests effect 0, bit1 requests effect 1.
REQ-011 grant  out  3  one-hot owner of the tone generator (bit0 BGM, bit1 SFX0, bit2 SFX1); all zeros when idle.
REQ-012 beat_idx  out  8  current beat index of the granted source.
REQ-013 beat_tick  out  1  one-cycle pulse at the end of each beat.
REQ-014 mute  out  1  high when no source is granted; drives the amplifier shutdown.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, BGM, SFX0, SFX1; grant SHALL be the one-hot encoding of the state, and mute SHALL equal (state==IDLE).
REQ-016 Priority SHALL be SFX1 > SFX0 > BGM.
REQ-017 Inputs are sampled on a clk edge, and grant SHALL change on that same edge, giving 1-cycle latency from sfx_req or bgm_en to grant.
REQ-018 The beat divider SHALL count CLK_HZ/BEAT_HZ cycles, assert beat_tick on the last count, and restart from 0 on every grant change.
REQ-019 On beat_tick, beat_idx SHALL increment; in BGM it SHALL wrap from BGM_BEATS-1 to 0.
REQ-020 SFXn SHALL end on the beat_tick where beat_idx==SFXn_BEATS-1; the next state SHALL be a pending SFX if one exists, else BGM if bgm_en is high, else IDLE.
REQ-021 An sfx_req[1] while in SFX0 SHALL preempt immediately; the preempted SFX0 is abandoned, not resumed.
REQ-022 A request for the currently playing SFX SHALL restart it at beat_idx 0 with the divider cleared.
REQ-023 When an SFX preempts BGM, the BGM beat position SHALL be saved; BGM SHALL resume from the saved index with a full-length first beat.
REQ-024 When bgm_en falls, the block SHALL leave BGM (to IDLE if no SFX is pending) and clear the saved BGM position to 0.
REQ-025 When both sfx_req bits are high in the same cycle, SFX1 SHALL be granted.
REQ-026 beat_idx SHALL be 0 on entry to any SFX and in IDLE.

Reset
REQ-027 When rst is high at a clk edge, the block SHALL set the state to IDLE, grant=3'b000, mute=1, beat_idx=0, beat_tick=0, the divider to 0, the saved BGM position to 0, and SHALL clear all pending flags.
REQ-028 Reset SHALL override all simultaneous requests; a reset in the middle of a beat SHALL produce no beat_tick.

Configuration
REQ-029 Macro SFX_QUEUE_EN SHALL control the pending-request feature.
REQ-030 With SFX_QUEUE_EN defined, an sfx_req[0] arriving during SFX1 (including the simultaneous case in REQ-025) SHALL set a one-deep pending flag; SFX0 SHALL play when SFX1 ends, and repeat requests SHALL not stack.
REQ-031 With SFX_QUEUE_EN undefined, a lower-priority request that is not granted SHALL be dropped, and no pending storage SHALL exist.

Verification (CLK_HZ=80, BEAT_HZ=8, so one beat = 10 cycles)
REQ-032 Assert bgm_en after reset -> next edge grant=001 and mute=0; beat_tick every 10 cycles; beat_idx wraps 127->0 after 1280 cycles.
REQ-033 In BGM at beat_idx 5, pulse sfx_req=01 -> grant=010, beat_idx=0; after 40 cycles grant=001 and beat_idx=5.
REQ-034 In SFX0, pulse sfx_req=10 -> next edge grant=100; after 160 cycles the block returns to BGM (or IDLE if bgm_en=0); SFX0 is not resumed.
REQ-035 From IDLE, pulse sfx_req=11 -> grant=100; with SFX_QUEUE_EN, after 160 cycles grant=010 for 40 cycles, then 000; without the macro, grant=000 after 160 cycles.
REQ-036 Assert rst mid-SFX1 at beat 7 -> next edge grant=000, mute=1, beat_idx=0, with no beat_tick; drop bgm_en mid-BGM -> grant=000 and BGM restarts at beat 0 when bgm_en is reasserted.
